// File: rtl/mem_writeback_stage_pkg.sv
// Shared widths, FSM state encoding and instruction-type encodings for the MEM/WB stage.
package mem_writeback_stage_pkg;

  localparam int N_DEF       = 24;
  localparam int REG_AW_DEF  = 4;
  localparam int MEM_AW_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  typedef enum logic [1:0] {
    OPT_ALU    = 2'd0,
    OPT_LOAD   = 2'd1,
    OPT_STORE  = 2'd2,
    OPT_BRANCH = 2'd3
  } op_type_t;

  function automatic logic is_memop(input logic valid, input logic mem_write,
                                    input logic mem_to_reg, input logic flush);
    return valid & (mem_write | mem_to_reg) & ~flush;
  endfunction

endpackage

// File: rtl/mem_writeback_stage_if.sv
// Data-memory request/ack bus between the MEM stage (master) and the memory (slave).
interface mem_writeback_stage_if
  import mem_writeback_stage_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int MEM_AW = MEM_AW_DEF
);
  logic              dmem_req;
  logic              dmem_we;
  logic [MEM_AW-1:0] dmem_addr;
  logic [N-1:0]      dmem_wdata;
  logic [N-1:0]      dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_writeback_stage_dmem_handshake_fsm.sv
// Request/ack FSM with timeout, latched request fields, stall generation and
// a hold of completed load data while the pipeline is frozen.
module dmem_handshake_fsm
  import mem_writeback_stage_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int MEM_AW  = MEM_AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              memop,
  input  logic              we_i,
  input  logic [MEM_AW-1:0] addr_i,
  input  logic [N-1:0]      wdata_i,
  mem_writeback_stage_if.master dmem,
  output logic              stall_o,
  output logic [N-1:0]      ld_data_o,
  output logic              kill_o,
  output logic              bus_err_o
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [N-1:0]      wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [N-1:0]      data_q, data_d;
  logic              done_q, done_d;
  logic              kill_q, kill_d;
  logic              err_q, err_d;

  logic              req, we, complete;
  logic [MEM_AW-1:0] addr;
  logic [N-1:0]      wdata, cdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    data_d    = data_q;
    done_d    = done_q;
    kill_d    = kill_q;
    err_d     = err_q;
    req       = 1'b0;
    we        = 1'b0;
    addr      = '0;
    wdata     = '0;
    stall_o   = 1'b0;
    complete  = 1'b0;
    cdata     = '0;
    ld_data_o = data_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // done_q: an access already finished while frozen; never reissue it
        if (memop && !done_q) begin
          req   = 1'b1;
          we    = we_i;
          addr  = addr_i;
          wdata = wdata_i;
          if (dmem.dmem_ack) begin
            complete  = 1'b1;
            cdata     = dmem.dmem_rdata;
            ld_data_o = dmem.dmem_rdata;
          end else begin
            stall_o = 1'b1;
            state_d = WAIT;
            addr_d  = addr_i;
            wdata_d = wdata_i;
            we_d    = we_i;
          end
        end
      end
      WAIT: begin
        req   = 1'b1;
        we    = we_q;
        addr  = addr_q;
        wdata = wdata_q;
        if (dmem.dmem_ack) begin
          complete  = 1'b1;
          cdata     = dmem.dmem_rdata;
          ld_data_o = dmem.dmem_rdata;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          complete  = 1'b1;
          ld_data_o = '0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          stall_o = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush seen while the instruction is held must still squash it at writeback
    if (flush && (state_q == WAIT || done_q)) kill_d = 1'b1;
    if (complete && !en) begin
      done_d = 1'b1;
      data_d = cdata;
    end
    if (en && !stall_o) begin
      done_d = 1'b0;
      kill_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      kill_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      data_q  <= data_d;
      done_q  <= done_d;
      kill_q  <= kill_d;
      err_q   <= err_d;
    end
  end

  assign dmem.dmem_req   = req;
  assign dmem.dmem_we    = we;
  assign dmem.dmem_addr  = addr;
  assign dmem.dmem_wdata = wdata;
  assign kill_o          = kill_q;
  assign bus_err_o       = err_q;

endmodule

// File: rtl/mem_writeback_stage.sv
// MEM and WB stages: data-memory access through the handshake FSM, MEM/WB register,
// writeback mux and the forwarding/hazard taps.
module mem_writeback_stage
  import mem_writeback_stage_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MEM_AW  = MEM_AW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [N-1:0]      aluOut,
  input  logic [N-1:0]      rd3,
  input  logic [REG_AW-1:0] Rc,
  input  logic              memWrite,
  input  logic              memToReg,
  input  logic              regWrite,
  input  logic [1:0]        opType,
  input  logic [3:0]        opCode,
  mem_writeback_stage_if.master dmem,
  output logic              WE,
  output logic [REG_AW-1:0] Rd,
  output logic [N-1:0]      WD,
  output logic [REG_AW-1:0] Rd_EXMEM,
  output logic [REG_AW-1:0] Rd_MEMWB,
  output logic [1:0]        opTypeMem,
  output logic [3:0]        opCodeMem,
  output logic [1:0]        opTypeWB,
  output logic [3:0]        opCodeWB,
  output logic [N-1:0]      Result,
  output logic              mem_stall,
  output logic              bus_err
);
  logic              memop, kill;
  logic [N-1:0]      ld_data;

  logic              wb_valid_q, wb_valid_d;
  logic              regwrite_q, regwrite_d;
  logic [REG_AW-1:0] rc_q, rc_d;
  logic              memtoreg_q, memtoreg_d;
  logic [N-1:0]      alu_q, alu_d;
  logic [N-1:0]      load_q, load_d;
  logic [1:0]        optype_q, optype_d;
  logic [3:0]        opcode_q, opcode_d;

  assign memop = is_memop(valid_in, memWrite, memToReg, flush);

  // MEM stage
  dmem_handshake_fsm #(
    .N       (N),
    .MEM_AW  (MEM_AW),
    .TIMEOUT (TIMEOUT)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .memop     (memop),
    .we_i      (memWrite),
    .addr_i    (aluOut[MEM_AW-1:0]),
    .wdata_i   (rd3),
    .dmem      (dmem),
    .stall_o   (mem_stall),
    .ld_data_o (ld_data),
    .kill_o    (kill),
    .bus_err_o (bus_err)
  );

  always_comb begin
    wb_valid_d = 1'b0;
    regwrite_d = 1'b0;
    rc_d       = '0;
    memtoreg_d = 1'b0;
    alu_d      = '0;
    load_d     = '0;
    optype_d   = '0;
    opcode_d   = '0;
    if (valid_in && !flush && !kill) begin
      wb_valid_d = 1'b1;
      regwrite_d = regWrite & ~memWrite;
      rc_d       = Rc;
      memtoreg_d = memToReg;
      alu_d      = aluOut;
      load_d     = ld_data;
      optype_d   = opType;
      opcode_d   = opCode;
    end
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid_q <= 1'b0;
      regwrite_q <= 1'b0;
      rc_q       <= '0;
      memtoreg_q <= 1'b0;
      alu_q      <= '0;
      load_q     <= '0;
      optype_q   <= '0;
      opcode_q   <= '0;
    end else if (en && !mem_stall) begin
      wb_valid_q <= wb_valid_d;
      regwrite_q <= regwrite_d;
      rc_q       <= rc_d;
      memtoreg_q <= memtoreg_d;
      alu_q      <= alu_d;
      load_q     <= load_d;
      optype_q   <= optype_d;
      opcode_q   <= opcode_d;
    end
  end

  // WB stage
  assign WE        = wb_valid_q & regwrite_q;
  assign Rd        = rc_q;
  assign WD        = memtoreg_q ? load_q : alu_q;
  assign Result    = WD;
  assign Rd_MEMWB  = rc_q;
  assign opTypeWB  = optype_q;
  assign opCodeWB  = opcode_q;
  assign Rd_EXMEM  = valid_in ? Rc : '0;
  assign opTypeMem = valid_in ? opType : '0;
  assign opCodeMem = valid_in ? opCode : '0;

endmodule
